// File: rtl/multicycle_control.sv
// multicycle_control: Moore sequencer for the multi-cycle MIPS datapath with mem_ready handshake and wait time-out.
module multicycle_control #(
  parameter int TIMEOUT = 16,
  parameter bit EN_ADDI = 1'b1,
  parameter bit EN_JUMP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        ir_write,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        regdst,
  output logic        reg_write,
  output logic        memtoreg,
  output logic        alusrc_a,
  output logic [1:0]  alusrc_b,
  output logic [1:0]  aluop,
  output logic [1:0]  pc_source,
  output logic [3:0]  state,
  output logic        mem_err,
  output logic        illegal
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, BRANCH, JUMP, ADDI_EX, ADDI_WB
  } state_t;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  state_t st, nxt;
  logic [CW-1:0] cnt;
  logic err_q, ill_q, mem_state, timeout;
  logic [5:0] op;
  logic unused_bits;
  assign op = instruction[31:26];
  assign unused_bits = ^instruction[25:0];
  assign mem_state = st == FETCH || st == MEMRD || st == MEMWR;
  assign timeout = mem_state && !mem_ready && cnt == LAST;
  always_comb begin
    nxt = FETCH;
    case (st)
      FETCH:   nxt = mem_ready ? DECODE : FETCH;
      DECODE:  nxt = op == 6'h00 ? EXEC :
                     (op == 6'h23 || op == 6'h2b) ? MEMADR :
                     op == 6'h04 ? BRANCH :
                     (EN_JUMP && op == 6'h02) ? JUMP :
                     (EN_ADDI && op == 6'h08) ? ADDI_EX : FETCH;
      MEMADR:  nxt = op == 6'h23 ? MEMRD : MEMWR;
      MEMRD:   nxt = mem_ready ? MEMWB : (timeout ? FETCH : MEMRD);
      MEMWR:   nxt = (mem_ready || timeout) ? FETCH : MEMWR;
      EXEC:    nxt = RWB;
      ADDI_EX: nxt = ADDI_WB;
      default: nxt = FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= FETCH;
      cnt <= '0;
      err_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      st <= nxt;
      cnt <= (nxt != st || mem_ready || timeout || !mem_state) ? '0 : cnt + 1'b1;
      err_q <= timeout;
      ill_q <= st == DECODE && nxt == FETCH;
    end
  end
  // Strobes come from the state register alone, except the FETCH commit which waits for mem_ready.
  always_comb begin
    {pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write} = '0;
    {regdst, reg_write, memtoreg, alusrc_a, alusrc_b, aluop, pc_source} = '0;
    if (!reset) begin
      case (st)
        FETCH:   begin mem_read = 1'b1; alusrc_b = 2'b01; ir_write = mem_ready; pc_write = mem_ready; end
        DECODE:  alusrc_b = 2'b11;
        MEMADR:  begin alusrc_a = 1'b1; alusrc_b = 2'b10; end
        MEMRD:   begin mem_read = 1'b1; iord = 1'b1; end
        MEMWB:   begin reg_write = 1'b1; memtoreg = 1'b1; end
        MEMWR:   begin mem_write = 1'b1; iord = 1'b1; end
        EXEC:    begin alusrc_a = 1'b1; aluop = 2'b10; end
        RWB:     begin regdst = 1'b1; reg_write = 1'b1; end
        BRANCH:  begin alusrc_a = 1'b1; aluop = 2'b01; pc_write_cond = 1'b1; pc_source = 2'b01; end
        JUMP:    begin pc_write = 1'b1; pc_source = 2'b10; end
        ADDI_EX: begin alusrc_a = 1'b1; alusrc_b = 2'b10; end
        ADDI_WB: reg_write = 1'b1;
        default: ;
      endcase
    end
  end
  assign state = reset ? 4'd0 : st;
  assign mem_err = !reset && err_q;
  assign illegal = !reset && ill_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed vectors against a default instance and a TIMEOUT=4 / no-jump instance.
module tb_multicycle_control;
  logic clk = 1'b0, reset = 1'b1, mem_ready = 1'b0;
  logic [31:0] instruction = 32'h0;
  logic [3:0] a_st, b_st;
  logic [15:0] a_ctl, b_ctl;
  logic [1:0] a_ef, b_ef, a_sb, b_sb, a_ao, b_ao, a_ps, b_ps;
  logic a_pw, a_pwc, a_irw, a_iord, a_mr, a_mw, a_rd, a_rw, a_m2r, a_sa;
  logic b_pw, b_pwc, b_irw, b_iord, b_mr, b_mw, b_rd, b_rw, b_m2r, b_sa;
  logic a_err, a_ill, b_err, b_ill;
  bit use_b = 1'b0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  multicycle_control dut_a (
    .clk(clk), .reset(reset), .instruction(instruction), .mem_ready(mem_ready),
    .pc_write(a_pw), .pc_write_cond(a_pwc), .ir_write(a_irw), .iord(a_iord),
    .mem_read(a_mr), .mem_write(a_mw), .regdst(a_rd), .reg_write(a_rw),
    .memtoreg(a_m2r), .alusrc_a(a_sa), .alusrc_b(a_sb), .aluop(a_ao),
    .pc_source(a_ps), .state(a_st), .mem_err(a_err), .illegal(a_ill)
  );
  multicycle_control #(.TIMEOUT(4), .EN_ADDI(1'b1), .EN_JUMP(1'b0)) dut_b (
    .clk(clk), .reset(reset), .instruction(instruction), .mem_ready(mem_ready),
    .pc_write(b_pw), .pc_write_cond(b_pwc), .ir_write(b_irw), .iord(b_iord),
    .mem_read(b_mr), .mem_write(b_mw), .regdst(b_rd), .reg_write(b_rw),
    .memtoreg(b_m2r), .alusrc_a(b_sa), .alusrc_b(b_sb), .aluop(b_ao),
    .pc_source(b_ps), .state(b_st), .mem_err(b_err), .illegal(b_ill)
  );
  assign a_ctl = {a_pw, a_pwc, a_irw, a_iord, a_mr, a_mw, a_rd, a_rw, a_m2r, a_sa, a_sb, a_ao, a_ps};
  assign b_ctl = {b_pw, b_pwc, b_irw, b_iord, b_mr, b_mw, b_rd, b_rw, b_m2r, b_sa, b_sb, b_ao, b_ps};
  assign a_ef = {a_err, a_ill};
  assign b_ef = {b_err, b_ill};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic rdy, input logic [3:0] es, input logic [15:0] ec, input logic [1:0] ef = 2'b00);
    mem_ready = rdy;
    #1;
    chk({tag, ".state"}, use_b ? b_st : a_st, es);
    chk({tag, ".ctl"}, use_b ? b_ctl : a_ctl, ec);
    chk({tag, ".err_ill"}, use_b ? b_ef : a_ef, ef);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.a_state", a_st, 0);
    chk("rst.a_ctl", a_ctl, 0);
    chk("rst.b_ctl", b_ctl, 0);
    chk("rst.err_ill", {a_ef, b_ef}, 0);
    reset = 1'b0;
  endtask
  initial begin
    @(posedge clk);
    #1;
    do_reset();
    instruction = 32'h8C080004;
    cyc("lw.f", 1, 0, 16'hA810); cyc("lw.d", 1, 1, 16'h0030); cyc("lw.ma", 1, 2, 16'h0060);
    cyc("lw.rd", 1, 3, 16'h1800); cyc("lw.wb", 1, 4, 16'h0180);
    instruction = 32'h01095020;
    cyc("r.f", 1, 0, 16'hA810); cyc("r.d", 0, 1, 16'h0030); cyc("r.ex", 0, 6, 16'h0048); cyc("r.wb", 1, 7, 16'h0300);
    instruction = 32'h11090003;
    cyc("beq.fw", 0, 0, 16'h0810); cyc("beq.f", 1, 0, 16'hA810); cyc("beq.d", 1, 1, 16'h0030); cyc("beq.br", 1, 8, 16'h4045);
    instruction = 32'hAD090008;
    cyc("sw.f", 1, 0, 16'hA810); cyc("sw.d", 1, 1, 16'h0030); cyc("sw.ma", 1, 2, 16'h0060);
    cyc("sw.w0", 0, 5, 16'h1400); cyc("sw.w1", 0, 5, 16'h1400); cyc("sw.w2", 0, 5, 16'h1400); cyc("sw.w3", 1, 5, 16'h1400);
    instruction = 32'h21080005;
    cyc("addi.f", 1, 0, 16'hA810); cyc("addi.d", 1, 1, 16'h0030); cyc("addi.ex", 1, 10, 16'h0060); cyc("addi.wb", 1, 11, 16'h0100);
    instruction = 32'h08000010;
    cyc("j.f", 1, 0, 16'hA810); cyc("j.d", 1, 1, 16'h0030); cyc("j.jp", 1, 9, 16'h8002); cyc("j.next", 1, 0, 16'hA810);
    use_b = 1'b1;
    do_reset();
    instruction = 32'h8C080004;
    cyc("to.f", 1, 0, 16'hA810); cyc("to.d", 1, 1, 16'h0030); cyc("to.ma", 1, 2, 16'h0060);
    for (int i = 0; i < 4; i++) cyc("to.rd", 0, 3, 16'h1800);
    cyc("to.err", 0, 0, 16'h0810, 2'b10); cyc("to.clr", 1, 0, 16'hA810);
    instruction = 32'h08000010;
    cyc("ill.d", 1, 1, 16'h0030); cyc("ill.f", 0, 0, 16'h0810, 2'b01);
    for (int i = 0; i < 3; i++) cyc("fto.f", 0, 0, 16'h0810);
    cyc("fto.err", 0, 0, 16'h0810, 2'b10); cyc("fto.go", 1, 0, 16'hA810);
    instruction = 32'h8C080004;
    cyc("mr.d", 1, 1, 16'h0030); cyc("mr.ma", 1, 2, 16'h0060); cyc("mr.rd", 0, 3, 16'h1800);
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("mr.rst_state", b_st, 0);
    chk("mr.rst_ctl", b_ctl, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cyc("mr.after", 0, 0, 16'h0810);
    cyc("mr.err", 0, 0, 16'h0810, 2'b10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
